// File: rtl/bcd_button_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_button_counter_if
// Bundles the button/switch inputs and the BCD result of bcd_button_counter.
//   btn_up, btn_down, btn_load : raw (unsynchronised, bouncing) push-buttons
//   sw[7:0]                    : load value {tens, ones}
//   bcd_out[7:0]               : current count {tens, ones}, always valid BCD
//   wrap                       : one-cycle pulse on 99->00 or 00->99
// master : the side that drives buttons/switches (board or bench)
// slave  : the counter itself
// -----------------------------------------------------------------------------
interface bcd_button_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [7:0] sw;
    logic [7:0] bcd_out;
    logic       wrap;

    modport master (
        output btn_up, btn_down, btn_load, sw,
        input  bcd_out, wrap
    );

    modport slave (
        input  btn_up, btn_down, btn_load, sw,
        output bcd_out, wrap
    );
endinterface

// File: rtl/bcd_button_counter.sv
// -----------------------------------------------------------------------------
// bcd_button_counter
// Turns three raw push-buttons into a two-digit BCD count (00-99) that feeds
// the seven-segment display block.
//   clk    : system clock (100 MHz)
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bcd_button_counter_if (buttons, sw, bcd_out, wrap)
// Each button passes through a 2-flop synchroniser, a counter-based debounce
// (DB_COUNT consecutive stable cycles) and a rising-edge detector, so a held
// button yields exactly one event and a release yields none.
// -----------------------------------------------------------------------------
module bcd_button_counter #(
    parameter int DB_COUNT = 500000,
    parameter int DB_W     = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bcd_button_counter_if.slave     bus
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

    // Bit positions of the three buttons in the per-button vectors.
    localparam int UP   = 0;
    localparam int DOWN = 1;
    localparam int LOAD = 2;

    logic [2:0]            raw;
    logic [2:0]            s1;
    logic [2:0]            s2;
    logic [2:0]            db;
    logic [2:0]            db_q;
    logic [2:0]            press;
    logic [2:0][DB_W-1:0]  cnt;

    logic [7:0]            bcd_q;
    logic                  wrap_q;
    logic [7:0]            bcd_d;
    logic                  wrap_d;
    logic [3:0]            tens;
    logic [3:0]            ones;

    assign raw = {bus.btn_load, bus.btn_down, bus.btn_up};

    // -------------------------------------------------------------------------
    // Synchronise, debounce and edge-detect all three buttons.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source (s1 -> s2 really is two flops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            cnt  <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == db[i]) begin
                    // Level agrees with accepted state: any partial count is
                    // a glitch and is thrown away.
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // One-cycle event on the debounced rising edge only.
    assign press = db & ~db_q;

    // -------------------------------------------------------------------------
    // Next count. Priority: load > (up & down cancel) > up > down > hold.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign tens = bcd_q[7:4];
    assign ones = bcd_q[3:0];

    // NOTE: both outputs get a default before any branch so no path through
    // the block leaves them unassigned (which would infer latches).
    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        if (press[LOAD]) begin
            bcd_d = {clamp9(bus.sw[7:4]), clamp9(bus.sw[3:0])};
        end else if (press[UP] && press[DOWN]) begin
            bcd_d = bcd_q;
        end else if (press[UP]) begin
            if (ones == 4'd9) begin
                if (tens == 4'd9) begin
                    bcd_d  = 8'h00;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d = {tens + 4'd1, 4'd0};
                end
            end else begin
                bcd_d = {tens, ones + 4'd1};
            end
        end else if (press[DOWN]) begin
            if (ones == 4'd0) begin
                if (tens == 4'd0) begin
                    bcd_d  = 8'h99;
                    wrap_d = 1'b1;
                end else begin
                    bcd_d = {tens - 4'd1, 4'd9};
                end
            end else begin
                bcd_d = {tens, ones - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q  <= 8'h00;
            wrap_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_button_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_button_counter
// Directed bench for bcd_button_counter with DB_COUNT = 4. A behavioural model
// tracks the count as an integer 0..99 and decides button acceptance from a
// window over the history of synchronised samples; a compare process checks
// bcd_out/wrap against it every cycle, and directed steps pin exact latencies.
// -----------------------------------------------------------------------------
module tb_bcd_button_counter;

    localparam int DBC = 4;

    logic clk;
    logic rst_n;

    bcd_button_counter_if bus ();

    bcd_button_counter #(.DB_COUNT(DBC), .DB_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit         rawq [3][$];
    bit         synq [3][$];
    bit   [2:0] m_db;
    bit   [2:0] m_pend;
    int         m_val;
    bit         m_wrap;

    function automatic int clamp_digit(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                rawq[b].delete();
                synq[b].delete();
            end
            m_db   = '0;
            m_pend = '0;
            m_val  = 0;
            m_wrap = 1'b0;
        end else begin
            bit [2:0] r;
            bit       all_diff;
            r = {bus.btn_load, bus.btn_down, bus.btn_up};

            // Events accepted on the previous edge change the count now.
            m_wrap = 1'b0;
            if (m_pend[2]) begin
                m_val = clamp_digit(int'(bus.sw[7:4])) * 10 + clamp_digit(int'(bus.sw[3:0]));
            end else if (m_pend[0] && m_pend[1]) begin
                m_val = m_val;
            end else if (m_pend[0]) begin
                m_wrap = (m_val == 99);
                m_val  = (m_val + 1) % 100;
            end else if (m_pend[1]) begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 99) % 100;
            end

            // Button seen by the logic is the raw level two edges ago; a new
            // level is accepted once DBC consecutive samples disagree with it.
            m_pend = '0;
            for (int b = 0; b < 3; b++) begin
                rawq[b].push_back(r[b]);
                if (rawq[b].size() > 8) void'(rawq[b].pop_front());
                synq[b].push_back(rawq[b].size() >= 3 ? rawq[b][rawq[b].size()-3] : 1'b0);
                if (synq[b].size() > 8) void'(synq[b].pop_front());
                all_diff = (synq[b].size() >= DBC);
                for (int j = 0; j < DBC && all_diff; j++)
                    if (synq[b][synq[b].size()-1-j] == m_db[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[b]   = ~m_db[b];
                    m_pend[b] = m_db[b];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_bcd", bus.bcd_out, to_bcd(m_val));
            check("model_wrap", {7'b0, bus.wrap}, {7'b0, m_wrap});
        end
    end

    // ------------------------------------------------------------- stimulus
    // Starts and ends on a negedge. Drives btns = {load, down, up} and expects
    // the count to stay at prev through edge 6 and become exp at edge 7.
    task automatic press_pulse(input logic [2:0] btns, input logic [7:0] swv,
                               input logic [7:0] prev, input logic [7:0] exp,
                               input logic exp_wrap);
        bus.sw = swv;
        {bus.btn_load, bus.btn_down, bus.btn_up} = btns;
        repeat (6) @(negedge clk);
        check("hold_before_edge7", bus.bcd_out, prev);
        @(negedge clk);
        check("update_edge7", bus.bcd_out, exp);
        check("wrap_edge7", {7'b0, bus.wrap}, {7'b0, exp_wrap});
        @(negedge clk);
        check("wrap_one_cycle", {7'b0, bus.wrap}, 8'h00);
        repeat (12) @(negedge clk);
        check("held_no_repeat", bus.bcd_out, exp);
        {bus.btn_load, bus.btn_down, bus.btn_up} = 3'b000;
        repeat (10) @(negedge clk);
        check("release_no_event", bus.bcd_out, exp);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_load = 1'b0;
        bus.sw       = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_bcd", bus.bcd_out, 8'h00);
        check("reset_wrap", {7'b0, bus.wrap}, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_change", bus.bcd_out, 8'h00);

        // Clean presses.
        press_pulse(3'b001, 8'h00, 8'h00, 8'h01, 1'b0);
        press_pulse(3'b001, 8'h00, 8'h01, 8'h02, 1'b0);

        // Bounce 1,0,1,0 then stable 1: one increment, 7 edges after last rise.
        bus.btn_up = 1'b1; @(negedge clk);
        bus.btn_up = 1'b0; @(negedge clk);
        bus.btn_up = 1'b1; @(negedge clk);
        bus.btn_up = 1'b0; @(negedge clk);
        press_pulse(3'b001, 8'h00, 8'h02, 8'h03, 1'b0);

        // Carry, borrow and wrap.
        press_pulse(3'b100, 8'h09, 8'h03, 8'h09, 1'b0);
        press_pulse(3'b001, 8'h00, 8'h09, 8'h10, 1'b0);
        press_pulse(3'b010, 8'h00, 8'h10, 8'h09, 1'b0);
        press_pulse(3'b100, 8'h99, 8'h09, 8'h99, 1'b0);
        press_pulse(3'b001, 8'h00, 8'h99, 8'h00, 1'b1);
        press_pulse(3'b010, 8'h00, 8'h00, 8'h99, 1'b1);
        press_pulse(3'b010, 8'h00, 8'h99, 8'h98, 1'b0);

        // Clamp and simultaneous events.
        press_pulse(3'b100, 8'hFA, 8'h98, 8'h99, 1'b0);
        press_pulse(3'b011, 8'h00, 8'h99, 8'h99, 1'b0);
        press_pulse(3'b101, 8'h42, 8'h99, 8'h42, 1'b0);

        // Asynchronous reset mid-cycle, in the middle of a debounce.
        bus.btn_up = 1'b1;
        repeat (3) @(negedge clk);
        #($urandom_range(1, 8));
        rst_n = 1'b0;
        #1;
        check("async_reset_bcd", bus.bcd_out, 8'h00);
        check("async_reset_wrap", {7'b0, bus.wrap}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no_early_after_reset", bus.bcd_out, 8'h00);
        @(negedge clk);
        check("inc_after_reset", bus.bcd_out, 8'h01);
        bus.btn_up = 1'b0;
        repeat (10) @(negedge clk);
        check("final_value", bus.bcd_out, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
